// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate scheduler and its lane FSMs.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OPEN = 2'd2
  } lane_state_e;

  localparam logic CAT_PUBLIC = 1'b0;
  localparam logic CAT_UNI    = 1'b1;

  localparam int DEF_OPEN_CYCLES = 8;
  localparam int DEF_HOLDOFF     = 2;

  // One event toward the counter core: pulse plus category.
  typedef struct packed {
    logic vld;
    logic is_uni;
  } core_evt_t;

  // (base + off) mod n for base, off < n, without a divider.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/parking_gate_lane.sv
// One gate lane: waits for an ack after a request, then holds its barrier
// open for OPEN_CYCLES clocks.
module parking_gate_lane
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic grant,
  input  logic reject,
  output logic waiting,
  output logic barrier_open
);

  localparam int CW = $clog2(OPEN_CYCLES + 1);

  lane_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        if (grant) begin
          state_nxt = OPEN;
          cnt_nxt   = CW'(OPEN_CYCLES);
        end else if (reject) begin
          state_nxt = IDLE;
        end
      end
      OPEN: begin
        // Leaving on the edge where the count hits 0 gives exactly OPEN_CYCLES open cycles.
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign waiting      = (state == WAIT);
  assign barrier_open = (state == OPEN);

endmodule

// File: rtl/parking_gate_scheduler.sv
// Round-robin arbitration of entry and exit lanes onto the shared counter core,
// with per-category entry holdoff while the core's vacancy flags settle.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int N_ENTRY     = 2,
  parameter int N_EXIT      = 2,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
  parameter int HOLDOFF     = DEF_HOLDOFF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_ENTRY-1:0]         entry_req,
  input  logic [N_ENTRY-1:0]         entry_is_uni,
  input  logic [N_EXIT-1:0]          exit_req,
  input  logic [N_EXIT-1:0]          exit_is_uni,
  input  logic                       uni_is_vacated_space,
  input  logic                       is_vacated_space,
  output logic                       car_entered,
  output logic                       is_uni_car_entered,
  output logic                       car_exited,
  output logic                       is_uni_car_exited,
  output logic [N_ENTRY-1:0]         entry_grant,
  output logic [N_ENTRY-1:0]         entry_reject,
  output logic [N_EXIT-1:0]          exit_grant,
  output logic [N_ENTRY+N_EXIT-1:0]  barrier_open
);

  localparam int NL  = N_ENTRY + N_EXIT;
  localparam int EPW = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
  localparam int XPW = (N_EXIT > 1) ? $clog2(N_EXIT) : 1;
  localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [NL-1:0]      lane_req, lane_grant, lane_reject, lane_wait;
  logic [EPW-1:0]     ent_ptr, ent_ptr_nxt;
  logic [XPW-1:0]     xit_ptr, xit_ptr_nxt;
  logic [HW-1:0]      hold_uni, hold_pub, hold_uni_nxt, hold_pub_nxt;
  logic [N_ENTRY-1:0] ent_oh, ent_grant_nxt, ent_reject_nxt;
  logic [N_EXIT-1:0]  xit_oh;
  logic               ent_found, ent_cat, ent_held, ent_room, xit_found;
  core_evt_t          ent_evt_nxt, xit_evt_nxt, ent_evt_q, xit_evt_q;

  assign lane_req    = {exit_req, entry_req};
  assign lane_grant  = {xit_oh, ent_grant_nxt};
  assign lane_reject = {{N_EXIT{1'b0}}, ent_reject_nxt};

  generate
    for (genvar g = 0; g < NL; g++) begin : g_lane
      parking_gate_lane #(.OPEN_CYCLES(OPEN_CYCLES)) u_lane (
        .clock        (clock),
        .reset        (reset),
        .req          (lane_req[g]),
        .grant        (lane_grant[g]),
        .reject       (lane_reject[g]),
        .waiting      (lane_wait[g]),
        .barrier_open (barrier_open[g])
      );
    end
  endgenerate

  // First waiting entry lane at or after the pointer, as a one-hot.
  always_comb begin
    ent_oh    = '0;
    ent_found = 1'b0;
    for (int i = 0; i < N_ENTRY; i++)
      for (int j = 0; j < N_ENTRY; j++)
        if (!ent_found && j == wrap_idx(int'(ent_ptr), i, N_ENTRY) && lane_wait[j]) begin
          ent_oh[j] = 1'b1;
          ent_found = 1'b1;
        end
  end

  assign ent_cat  = |(entry_is_uni & ent_oh);
  assign ent_held = (ent_cat == CAT_UNI) ? (hold_uni != '0) : (hold_pub != '0);
  assign ent_room = (ent_cat == CAT_UNI) ? uni_is_vacated_space : is_vacated_space;

  // A held winner stalls the whole entry side so it keeps its priority.
  assign ent_grant_nxt   = (ent_found && !ent_held &&  ent_room) ? ent_oh : '0;
  assign ent_reject_nxt  = (ent_found && !ent_held && !ent_room) ? ent_oh : '0;
  assign ent_evt_nxt.vld    = |ent_grant_nxt;
  assign ent_evt_nxt.is_uni = (|ent_grant_nxt) & ent_cat;

  always_comb begin
    ent_ptr_nxt = ent_ptr;
    for (int j = 0; j < N_ENTRY; j++)
      if (ent_oh[j] && !ent_held) ent_ptr_nxt = EPW'(wrap_idx(j, 1, N_ENTRY));
  end

  always_comb begin
    hold_uni_nxt = (hold_uni != '0) ? hold_uni - 1'b1 : '0;
    hold_pub_nxt = (hold_pub != '0) ? hold_pub - 1'b1 : '0;
    if (ent_evt_nxt.vld) begin
      if (ent_cat == CAT_UNI) hold_uni_nxt = HW'(HOLDOFF);
      else                    hold_pub_nxt = HW'(HOLDOFF);
    end
  end

  // Exit side: same rotation, never rejected, no holdoff.
  always_comb begin
    xit_oh    = '0;
    xit_found = 1'b0;
    for (int i = 0; i < N_EXIT; i++)
      for (int j = 0; j < N_EXIT; j++)
        if (!xit_found && j == wrap_idx(int'(xit_ptr), i, N_EXIT) && lane_wait[N_ENTRY + j]) begin
          xit_oh[j] = 1'b1;
          xit_found = 1'b1;
        end
  end

  assign xit_evt_nxt.vld    = xit_found;
  assign xit_evt_nxt.is_uni = |(exit_is_uni & xit_oh);

  always_comb begin
    xit_ptr_nxt = xit_ptr;
    for (int j = 0; j < N_EXIT; j++)
      if (xit_oh[j]) xit_ptr_nxt = XPW'(wrap_idx(j, 1, N_EXIT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_ptr      <= '0;
      xit_ptr      <= '0;
      hold_uni     <= '0;
      hold_pub     <= '0;
      entry_grant  <= '0;
      entry_reject <= '0;
      exit_grant   <= '0;
      ent_evt_q    <= '0;
      xit_evt_q    <= '0;
    end else begin
      ent_ptr      <= ent_ptr_nxt;
      xit_ptr      <= xit_ptr_nxt;
      hold_uni     <= hold_uni_nxt;
      hold_pub     <= hold_pub_nxt;
      entry_grant  <= ent_grant_nxt;
      entry_reject <= ent_reject_nxt;
      exit_grant   <= xit_oh;
      ent_evt_q    <= ent_evt_nxt;
      xit_evt_q    <= xit_evt_nxt;
    end
  end

  assign car_entered        = ent_evt_q.vld;
  assign is_uni_car_entered = ent_evt_q.is_uni;
  assign car_exited         = xit_evt_q.vld;
  assign is_uni_car_exited  = xit_evt_q.is_uni;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed scenarios then random traffic, checked each cycle against a
// timestamp-based model of lane waits, barrier windows and holdoff spacing.
module tb_parking_gate_scheduler;

  localparam int NE = 2, NX = 2, NL = NE + NX, OC = 8, HO = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NE-1:0] entry_req = '0, entry_is_uni = '0, entry_grant, entry_reject;
  logic [NX-1:0] exit_req = '0, exit_is_uni = '0, exit_grant;
  logic          uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic          car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [NL-1:0] barrier_open;

  always #5 clock = ~clock;

  parking_gate_scheduler #(.N_ENTRY(NE), .N_EXIT(NX), .OPEN_CYCLES(OC), .HOLDOFF(HO)) dut (
    .clock                (clock),
    .reset                (reset),
    .entry_req            (entry_req),
    .entry_is_uni         (entry_is_uni),
    .exit_req             (exit_req),
    .exit_is_uni          (exit_is_uni),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_grant          (entry_grant),
    .entry_reject         (entry_reject),
    .exit_grant           (exit_grant),
    .barrier_open         (barrier_open)
  );

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: edge index, per-lane wait start / grant edge, last grant edge per category.
  int mn, e_ptr, x_ptr;
  int wait_from [NL];
  int open_start [NL];
  int last_grant [2];
  logic [NE-1:0] x_eg, x_er;
  logic [NX-1:0] x_xg;
  logic          x_ce, x_cu, x_cx, x_xu;
  logic [NL-1:0] x_bo;

  bit hold_reqs = 0;
  int n_ce, n_cx, n_rej, n_both;
  int bo_cnt [NL];
  int g_edge [NE];
  int gq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mn = 0; e_ptr = 0; x_ptr = 0;
    for (int l = 0; l < NL; l++) begin wait_from[l] = -1; open_start[l] = -1000; end
    last_grant[0] = -1000; last_grant[1] = -1000;
  endtask

  task automatic clear_tallies();
    n_ce = 0; n_cx = 0; n_rej = 0; n_both = 0;
    for (int l = 0; l < NL; l++) bo_cnt[l] = 0;
    for (int l = 0; l < NE; l++) g_edge[l] = -100;
    gq.delete();
  endtask

  // Predict register contents after the coming edge from the inputs now applied.
  task automatic model_edge();
    logic [NL-1:0] req, acked;
    bit found;
    int w, u, l;
    req = {exit_req, entry_req};
    acked = '0;
    x_eg = '0; x_er = '0; x_xg = '0; x_ce = 0; x_cu = 0; x_cx = 0; x_xu = 0;
    found = 0; w = 0;
    for (int i = 0; i < NE; i++) begin
      l = (e_ptr + i) % NE;
      if (!found && wait_from[l] >= 0) begin found = 1; w = l; end
    end
    if (found) begin
      u = entry_is_uni[w] ? 1 : 0;
      if (mn - last_grant[u] > HO) begin
        acked[w] = 1'b1; wait_from[w] = -1; e_ptr = (w + 1) % NE;
        if ((u == 1) ? uni_is_vacated_space : is_vacated_space) begin
          x_eg[w] = 1'b1; x_ce = 1'b1; x_cu = (u == 1);
          last_grant[u] = mn; open_start[w] = mn;
        end else x_er[w] = 1'b1;
      end
    end
    found = 0; w = 0;
    for (int i = 0; i < NX; i++) begin
      l = (x_ptr + i) % NX;
      if (!found && wait_from[NE + l] >= 0) begin found = 1; w = l; end
    end
    if (found) begin
      x_xg[w] = 1'b1; x_cx = 1'b1; x_xu = exit_is_uni[w];
      x_ptr = (w + 1) % NX; acked[NE + w] = 1'b1;
      wait_from[NE + w] = -1; open_start[NE + w] = mn;
    end
    for (int k = 0; k < NL; k++) begin
      if (!acked[k] && wait_from[k] < 0 && req[k] &&
          !(open_start[k] <= mn - 1 && mn - 1 < open_start[k] + OC))
        wait_from[k] = mn;
      x_bo[k] = (open_start[k] <= mn) && (mn < open_start[k] + OC);
    end
    mn++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
    chk("entry_grant", 32'(entry_grant), 32'(x_eg));
    chk("entry_reject", 32'(entry_reject), 32'(x_er));
    chk("exit_grant", 32'(exit_grant), 32'(x_xg));
    chk("car_entered", 32'(car_entered), 32'(x_ce));
    chk("car_exited", 32'(car_exited), 32'(x_cx));
    chk("barrier_open", 32'(barrier_open), 32'(x_bo));
    if (x_ce) chk("is_uni_car_entered", 32'(is_uni_car_entered), 32'(x_cu));
    if (x_cx) chk("is_uni_car_exited", 32'(is_uni_car_exited), 32'(x_xu));
    if (car_entered) n_ce++;
    if (car_exited) n_cx++;
    if (car_entered && car_exited) n_both++;
    if (|entry_reject) n_rej++;
    for (int l = 0; l < NL; l++) if (barrier_open[l]) bo_cnt[l]++;
    for (int l = 0; l < NE; l++) if (entry_grant[l]) begin g_edge[l] = cyc; gq.push_back(l); end
    if (!hold_reqs) begin
      entry_req = entry_req & ~(x_eg | x_er);
      exit_req  = exit_req & ~x_xg;
    end
  endtask

  initial begin
    model_reset();
    clear_tallies();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({entry_grant, entry_reject, exit_grant, car_entered,
        is_uni_car_entered, car_exited, is_uni_car_exited, barrier_open}), 32'd0);
    reset = 1'b0;

    // Single uni entry
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    entry_is_uni[0] = 1'b1; entry_req[0] = 1'b1;
    repeat (14) step();
    chk("s1_entry_pulses", n_ce, 1);
    chk("s1_barrier_len", bo_cnt[0], OC);

    // Full lot for public cars
    clear_tallies();
    is_vacated_space = 1'b0;
    entry_is_uni[1] = 1'b0; entry_req[1] = 1'b1;
    repeat (4) step();
    chk("s2_reject_pulses", n_rej, 1);
    chk("s2_no_entry", n_ce, 0);
    chk("s2_barrier_closed", bo_cnt[1], 0);

    // Holdoff spacing between two uni entries
    clear_tallies();
    is_vacated_space = 1'b1;
    entry_is_uni = 2'b11; entry_req = 2'b11;
    repeat (8) step();
    chk("s3_holdoff_gap", (g_edge[1] > g_edge[0]) ? g_edge[1] - g_edge[0] : g_edge[0] - g_edge[1], HO + 1);
    repeat (12) step();

    // Uni flag drops during holdoff: the second lane is rejected
    clear_tallies();
    entry_is_uni = 2'b11; entry_req = 2'b11;
    repeat (2) step();
    uni_is_vacated_space = 1'b0;
    repeat (6) step();
    chk("s3b_reject", n_rej, 1);
    chk("s3b_one_entry", n_ce, 1);
    uni_is_vacated_space = 1'b1;
    repeat (12) step();

    // Fairness under continuous requests
    clear_tallies();
    hold_reqs = 1;
    entry_is_uni = 2'b00; entry_req = 2'b11;
    repeat (40) step();
    hold_reqs = 0;
    entry_req = '0;
    repeat (14) step();
    chk("s4_enough_grants", 32'(gq.size() >= 4), 32'd1);
    if (gq.size() >= 4)
      for (int i = 1; i < 4; i++) chk("s4_alternation", gq[i], (gq[0] + i) % NE);

    // Entry and exit in the same cycle
    clear_tallies();
    entry_is_uni[0] = 1'b1; entry_req[0] = 1'b1;
    exit_is_uni[1] = 1'b1; exit_req[1] = 1'b1;
    repeat (4) step();
    chk("s5_concurrent", n_both, 1);
    repeat (12) step();

    // Reset while an exit barrier is open
    exit_is_uni[0] = 1'b0; exit_req[0] = 1'b1;
    repeat (4) step();
    chk("s6_barrier_up", 32'(barrier_open[2]), 32'd1);
    #2;
    reset = 1'b1; entry_req = '0; exit_req = '0;
    #1;
    chk("s6_async_close", 32'(barrier_open), 32'd0);
    chk("s6_async_pulses", 32'({car_entered, car_exited, entry_grant, exit_grant}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    clear_tallies();
    repeat (6) step();
    chk("s6_quiet", n_ce + n_cx + n_rej, 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      for (int l = 0; l < NE; l++)
        if (!entry_req[l] && $urandom_range(3) == 0) begin
          entry_is_uni[l] = 1'($urandom_range(1)); entry_req[l] = 1'b1;
        end
      for (int l = 0; l < NX; l++)
        if (!exit_req[l] && $urandom_range(3) == 0) begin
          exit_is_uni[l] = 1'($urandom_range(1)); exit_req[l] = 1'b1;
        end
      if ($urandom_range(7) == 0) uni_is_vacated_space = ~uni_is_vacated_space;
      if ($urandom_range(7) == 0) is_vacated_space = ~is_vacated_space;
      step();
    end
    entry_req = '0; exit_req = '0;
    repeat (14) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
